// File: rtl/exec_hazard_ctrl.sv
// Execute-stage sequencing: load-use interlock, data-memory stall with timeout trap, and redirect flush.
// Mealy outputs with zero latency; holds freeze fetch/decode/execute while memory withholds memReady. Optional STALL_CNT_EN adds the stall counter.
module exec_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idValid,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic                  idUseRs1,
    input  logic                  idUseRs2,
    input  logic                  exValid,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic                  exRegWrite,
    input  logic [1:0]            exMemOp,
    input  logic                  pcSel,
    input  logic                  memReady,
    output logic                  holdFetch,
    output logic                  holdDecode,
    output logic                  holdExec,
    output logic                  flushDecode,
    output logic                  bubbleExec,
    output logic                  errMemTimeout,
    output logic [31:0]           stallCycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, ERROR} state_t;

    localparam int WAIT_W  = $clog2(MEM_TIMEOUT) + 1;
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [FLUSH_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic                mem_op, load_use, rs1_hit, rs2_hit;

    assign mem_op   = exValid & ((exMemOp == 2'b01) | (exMemOp == 2'b10));
    assign rs1_hit  = idUseRs1 & (idRs1 == exRd);
    assign rs2_hit  = idUseRs2 & (idRs2 == exRd);
    assign load_use = exValid & (exMemOp == 2'b01) & exRegWrite & (exRd != '0)
                    & idValid & (rs1_hit | rs2_hit);

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        holdFetch     = 1'b0;
        holdDecode    = 1'b0;
        holdExec      = 1'b0;
        flushDecode   = 1'b0;
        bubbleExec    = 1'b0;
        errMemTimeout = 1'b0;
        if (rst) begin
            flushDecode = 1'b1;
            bubbleExec  = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (exValid & pcSel) begin
                        flushDecode = 1'b1;
                        bubbleExec  = 1'b1;
                        flush_cnt_d = FLUSH_LOAD;
                        if (FLUSH_LOAD != '0) state_d = FLUSH;
                    end else if (mem_op & ~memReady) begin
                        holdFetch  = 1'b1;
                        holdDecode = 1'b1;
                        holdExec   = 1'b1;
                        wait_cnt_d = WAIT_W'(1);
                        state_d    = MEM_WAIT;
                    end else if (load_use) begin
                        // Execute drains the load while a NOP fills behind it.
                        holdFetch  = 1'b1;
                        holdDecode = 1'b1;
                        bubbleExec = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (memReady) begin
                        state_d = RUN;
                    end else begin
                        holdFetch  = 1'b1;
                        holdDecode = 1'b1;
                        holdExec   = 1'b1;
                        if (wait_cnt_q == WAIT_MAX) state_d = ERROR;
                        else wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                FLUSH: begin
                    flushDecode = 1'b1;
                    bubbleExec  = 1'b1;
                    flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
                    if (flush_cnt_q == FLUSH_W'(1)) state_d = RUN;
                end
                ERROR: begin
                    holdFetch     = 1'b1;
                    holdDecode    = 1'b1;
                    holdExec      = 1'b1;
                    errMemTimeout = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb stall_cnt_d = stall_cnt_q + {31'd0, holdFetch};

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stallCycles = stall_cnt_q;
`else
    assign stallCycles = '0;
`endif

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Scoreboard bench for exec_hazard_ctrl: stimulus pushes expected outputs, a negedge monitor pops and compares.
module tb_exec_hazard_ctrl;

    localparam int RW = 5;
    localparam int FC = 2;
    localparam int MT = 15;

    logic          clk = 1'b0;
    logic          rst, idValid, idUseRs1, idUseRs2, exValid, exRegWrite, pcSel, memReady;
    logic [RW-1:0] idRs1, idRs2, exRd;
    logic [1:0]    exMemOp;
    logic          holdFetch, holdDecode, holdExec, flushDecode, bubbleExec, errMemTimeout;
    logic [31:0]   stallCycles;

    always #5 clk = ~clk;

    exec_hazard_ctrl #(.REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2),
        .idUseRs1(idUseRs1), .idUseRs2(idUseRs2), .exValid(exValid), .exRd(exRd),
        .exRegWrite(exRegWrite), .exMemOp(exMemOp), .pcSel(pcSel), .memReady(memReady),
        .holdFetch(holdFetch), .holdDecode(holdDecode), .holdExec(holdExec),
        .flushDecode(flushDecode), .bubbleExec(bubbleExec), .errMemTimeout(errMemTimeout),
        .stallCycles(stallCycles)
    );

    typedef struct {
        string       tag;
        logic [5:0]  ctl;    // {holdFetch, holdDecode, holdExec, flushDecode, bubbleExec, err}
        logic [31:0] stall;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: trap flag, remaining flush cycles, length of the current memory stall.
    bit          m_err = 1'b0;
    int          m_flush_left = 0;
    int          m_stall_len = 0;
    logic [31:0] m_stall_total = '0;

    task automatic cycle(input string tag);
        exp_t e;
        bit hf, hd, he, fl, bu, er, is_mem, is_lu;
        {hf, hd, he, fl, bu, er} = 6'b0;
        e.tag   = tag;
        e.stall = m_stall_total;
        is_mem  = exValid && (exMemOp == 2'd1 || exMemOp == 2'd2);
        is_lu   = exValid && exMemOp == 2'd1 && exRegWrite && exRd != 0 && idValid &&
                  ((idUseRs1 && idRs1 == exRd) || (idUseRs2 && idRs2 == exRd));
        if (rst) begin
            fl = 1; bu = 1;
            m_err = 0; m_flush_left = 0; m_stall_len = 0;
        end else if (m_err) begin
            hf = 1; hd = 1; he = 1; er = 1;
        end else if (m_flush_left > 0) begin
            fl = 1; bu = 1;
            m_flush_left--;
        end else if (m_stall_len > 0) begin
            if (memReady) m_stall_len = 0;
            else begin
                hf = 1; hd = 1; he = 1;
                if (m_stall_len == MT) begin m_err = 1; m_stall_len = 0; end
                else m_stall_len++;
            end
        end else if (exValid && pcSel) begin
            fl = 1; bu = 1;
            m_flush_left = FC - 1;
        end else if (is_mem && !memReady) begin
            hf = 1; hd = 1; he = 1;
            m_stall_len = 1;
        end else if (is_lu) begin
            hf = 1; hd = 1; bu = 1;
        end
`ifdef STALL_CNT_EN
        if (rst) m_stall_total = '0;
        else if (hf) m_stall_total = m_stall_total + 32'd1;
`endif
        e.ctl = {hf, hd, he, fl, bu, er};
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; idValid = 0; idUseRs1 = 0; idUseRs2 = 0; exValid = 0; exRegWrite = 0;
        pcSel = 0; memReady = 1; idRs1 = 0; idRs2 = 0; exRd = 0; exMemOp = 2'd0;
    endtask

    task automatic load_use_setup();
        idle();
        exValid = 1; exMemOp = 2'd1; exRegWrite = 1; exRd = 5;
        idValid = 1; idUseRs1 = 1; idRs1 = 5;
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        logic [5:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {holdFetch, holdDecode, holdExec, flushDecode, bubbleExec, errMemTimeout};
                checks++;
                if (got !== e.ctl) begin
                    failures++;
                    $display("FAIL %s ctl got=%b want=%b", e.tag, got, e.ctl);
                end
                checks++;
                if (stallCycles !== e.stall) begin
                    failures++;
                    $display("FAIL %s stallCycles got=%0d want=%0d", e.tag, stallCycles, e.stall);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        cycle("reset0");
        cycle("reset1");
        idle();
        cycle("idle");

        load_use_setup();
        cycle("load_use");
        exMemOp = 2'd0;
        cycle("load_use_clear");
        load_use_setup(); exRd = 0; idRs1 = 0;
        cycle("no_stall_rd0");
        load_use_setup(); idUseRs1 = 0;
        cycle("no_stall_nouse");
        load_use_setup(); idUseRs1 = 0; idUseRs2 = 1; idRs2 = 5;
        cycle("load_use_rs2");
        idle(); exValid = 1; exMemOp = 2'd3; memReady = 0;
        cycle("reserved_op");

        idle(); exValid = 1; pcSel = 1;
        cycle("redirect");
        cycle("flush_pcsel_again");
        idle();
        cycle("flush_done");
        cycle("flush_idle");

        idle(); exValid = 1; exMemOp = 2'd2; memReady = 0;
        for (int i = 0; i < 3; i++) cycle("mem_stall");
        memReady = 1;
        cycle("mem_release");
        idle();
        cycle("after_release");

        idle(); exValid = 1; exMemOp = 2'd1; exRegWrite = 1; exRd = 3; memReady = 0;
        for (int i = 0; i < 20; i++) cycle("timeout");
        memReady = 1;
        for (int i = 0; i < 3; i++) cycle("err_sticky");
        rst = 1;
        cycle("err_reset");
        idle();
        cycle("err_cleared");

        idle(); exValid = 1; exMemOp = 2'd2; memReady = 0;
        for (int i = 0; i < 3; i++) cycle("wait_pre_rst");
        rst = 1;
        cycle("rst_mid_wait");
        idle();
        cycle("post_rst0");
        cycle("post_rst1");

        for (int i = 0; i < 2000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            idValid    = $urandom_range(0, 1);
            idUseRs1   = $urandom_range(0, 1);
            idUseRs2   = $urandom_range(0, 1);
            idRs1      = RW'($urandom_range(0, 3));
            idRs2      = RW'($urandom_range(0, 3));
            exValid    = ($urandom_range(0, 3) != 0);
            exRd       = RW'($urandom_range(0, 3));
            exRegWrite = $urandom_range(0, 1);
            exMemOp    = 2'($urandom_range(0, 3));
            pcSel      = ($urandom_range(0, 7) == 0);
            memReady   = ($urandom_range(0, 3) != 0);
            cycle("random");
        end

        idle();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
